cs2fifoc: RTL
=============

Name: cs2fifoc

Overview:
- Transmit-side counterpart of the command-frame receiver. Serializes a set of configuration fields into one checksummed byte frame and pushes it into the command FIFO, one byte per accepted cycle.
- Frame layout: 0x55, 0xAA, nine field bytes, zero padding, trailing 8-bit checksum. A receiver that checks header and checksum reproduces the same nine fields.
- Started and closed by the system controller through the codebase's fs/fd handshake.

Parameters:
- HEAD, 16'h55AA: frame header, high byte sent first.
- LEN_MIN, 12'd12: minimum legal data_len (header + 9 fields + checksum).
- LEN_MAX, 12'd32: maximum legal data_len (receiver cache depth in bytes).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- fs  in  1  frame start / hold request.
- fd  out  1  frame done.
- err  out  1  sticky status of the last frame; 1 means data_len was illegal.
- data_len  in  12  total frame length in bytes.
- kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1  in  8 each  field bytes.
- fifoc_full  in  1  FIFO cannot accept a write this cycle.
- fifoc_txen  out  1  FIFO write enable.
- fifoc_txd  out  8  FIFO write data.
- so  out  8  current state code, for debug.

Behaviour:
- Reset (rst=0, async): state=IDLE, err=0, fd=0, fifoc_txen=0, fifoc_txd=0, counters, checksum and latched fields = 0.
- States and encodings: IDLE=00, LOAD=01, HEAD=02, BODY=03, CSUM=04, LAST=0F; so = state.
- IDLE: when fs=1, go to LOAD.
- LOAD (exactly 1 cycle):
  - Latch all nine fields and data_len. Clear the checksum and set byte index idx=0.
  - If LEN_MIN <= data_len <= LEN_MAX: err<=0 and go to HEAD.
  - Otherwise: err<=1 and go directly to LAST. No FIFO write occurs.
- Write rule in HEAD/BODY/CSUM: fifoc_txen = !fifoc_full. fifoc_txd is combinational from state and idx. idx advances only on a cycle with txen=1. When fifoc_full=1, state, idx and checksum all hold.
- HEAD: sends idx0=HEAD[15:8], then idx1=HEAD[7:0]. After idx1 is accepted, go to BODY.
- BODY: covers idx 2..len-2.
  - idx 2..10 carry, in order: kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1.
  - idx 11..len-2 carry 0x00.
  - Each accepted byte is added to the checksum, 8-bit wrap-around.
  - After idx len-2 is accepted, go to CSUM.
- CSUM: sends the accumulated checksum (sum mod 256 of bytes 2..len-2) at idx len-1. On accept, go to LAST.
- LAST: fd=1. Stay while fs=1; go to IDLE when fs=0. If fs is already 0 on entry, fd is high for exactly one cycle.
- fs falling mid-frame is ignored; the frame always completes.
- Latency: first write occurs 2 cycles after fs is sampled high. A legal frame with no stalls takes data_len consecutive txen cycles.
- Input fields changing after LOAD do not affect the frame in flight.
- err and the latched fields keep their values until the next LOAD.
- Async reset mid-frame aborts immediately; no further writes occur.

Decomposition:
- Shared package holds HEAD, LEN_MIN, LEN_MAX, the state encodings, and the field-order index constants (FIELD_BASE=2, FIELD_CNT=9). These constants are common with the receiver.
- One sub-module, frame_byte_mux: combinational selection of the output byte from state, idx, latched fields and checksum.
- Counter and FSM stay in the top module.

Test Plan:
- data_len=12, fields 01..09 (kind_dev=01 … cmd_mix1=09), fifoc_full=0, fs pulse held -> exactly 12 txen cycles carrying 55 AA 01 02 03 04 05 06 07 08 09 2D. First txen 2 cycles after fs. fd=1 until fs=0. err=0.
- data_len=16, same fields -> 55 AA 01..09 00 00 00 00 2D, 16 txen cycles.
- data_len=12, all fields FF -> checksum byte F7 (9×255 mod 256).
- data_len=12, fifoc_full=1 for 3 cycles while idx=4 is pending -> no txen during those cycles, byte stream unchanged, 15 cycles from first to last write.
- data_len=8, then separately data_len=33 -> err=1, zero txen cycles, LOAD→LAST, fd asserted. A following legal frame clears err to 0.
- rst=0 asserted at idx=6, then released and fs reapplied -> txen drops at once, state=IDLE with all outputs 0. The next frame is complete from 55 with a correct checksum.

Source files
------------

// File: rtl/cs2fifoc_pkg.sv
// Constants shared between the command-frame transmitter and its receiver:
// header, legal length window, field layout and the state codes.
package cs2fifoc_pkg;

    localparam logic [15:0] HEAD       = 16'h55AA;
    localparam logic [11:0] LEN_MIN    = 12'd12;
    localparam logic [11:0] LEN_MAX    = 12'd32;
    localparam int          FIELD_BASE = 2;
    localparam int          FIELD_CNT  = 9;

    typedef enum logic [7:0] {
        S_IDLE = 8'h00,
        S_LOAD = 8'h01,
        S_HEAD = 8'h02,
        S_BODY = 8'h03,
        S_CSUM = 8'h04,
        S_LAST = 8'h0F
    } state_e;

    function automatic logic len_ok(input logic [11:0] len);
        return (len >= LEN_MIN) && (len <= LEN_MAX);
    endfunction

endpackage

// File: rtl/cs2fifoc_frame_byte_mux.sv
// Selects the byte presented to the FIFO from the current state, byte index,
// latched fields and running checksum. Purely combinational.
module frame_byte_mux
    import cs2fifoc_pkg::*;
(
    input  logic [7:0]             i_state,
    input  logic [11:0]            i_idx,
    input  logic [FIELD_CNT*8-1:0] i_fields,
    input  logic [7:0]             i_csum,
    output logic [7:0]             o_byte
);

    always_comb begin
        o_byte = 8'h00;
        case (i_state)
            S_HEAD: o_byte = (i_idx == 12'd0) ? HEAD[15:8] : HEAD[7:0];
            S_BODY: begin
                // Indices past the last field are zero padding.
                for (int i = 0; i < FIELD_CNT; i++) begin
                    if (i_idx == 12'(FIELD_BASE + i)) begin
                        o_byte = i_fields[i*8 +: 8];
                    end
                end
            end
            S_CSUM: o_byte = i_csum;
            default: o_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/cs2fifoc.sv
// Command-frame transmitter: latches nine configuration fields and pushes a
// headered, zero-padded, checksummed frame into the command FIFO.
//
// state | meaning
// IDLE  | waiting for fs
// LOAD  | latch fields and length, validate length
// HEAD  | send the two header bytes
// BODY  | send fields then padding, accumulate checksum
// CSUM  | send checksum byte
// LAST  | fd high until fs drops
module cs2fifoc
    import cs2fifoc_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fs,
    output logic        o_fd,
    output logic        o_err,
    input  logic [11:0] i_data_len,
    input  logic [7:0]  i_kind_dev,
    input  logic [7:0]  i_info_sr,
    input  logic [7:0]  i_cmd_filt,
    input  logic [7:0]  i_cmd_mix0,
    input  logic [7:0]  i_cmd_reg4,
    input  logic [7:0]  i_cmd_reg5,
    input  logic [7:0]  i_cmd_reg6,
    input  logic [7:0]  i_cmd_reg7,
    input  logic [7:0]  i_cmd_mix1,
    input  logic        i_fifoc_full,
    output logic        o_fifoc_txen,
    output logic [7:0]  o_fifoc_txd,
    output logic [7:0]  o_so
);

    state_e                 r_state;
    state_e                 w_next;
    logic [11:0]            r_idx;
    logic [11:0]            r_len;
    logic [7:0]             r_csum;
    logic [FIELD_CNT*8-1:0] r_fields;
    logic                   r_err;
    logic                   w_active;
    logic                   w_txen;
    logic [7:0]             w_byte;
    logic [11:0]            w_body_end;

    assign w_active   = (r_state == S_HEAD) || (r_state == S_BODY) || (r_state == S_CSUM);
    assign w_txen     = w_active && !i_fifoc_full;
    assign w_body_end = r_len - 12'd2;

    frame_byte_mux u_mux (
        .i_state  (r_state),
        .i_idx    (r_idx),
        .i_fields (r_fields),
        .i_csum   (r_csum),
        .o_byte   (w_byte)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_fs) w_next = S_LOAD;
            S_LOAD: w_next = len_ok(i_data_len) ? S_HEAD : S_LAST;
            S_HEAD: if (w_txen && r_idx == 12'd1) w_next = S_BODY;
            S_BODY: if (w_txen && r_idx == w_body_end) w_next = S_CSUM;
            S_CSUM: if (w_txen) w_next = S_LAST;
            S_LAST: if (!i_fs) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_len    <= '0;
            r_csum   <= '0;
            r_fields <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_LOAD) begin
                r_fields <= {i_cmd_mix1, i_cmd_reg7, i_cmd_reg6, i_cmd_reg5, i_cmd_reg4,
                             i_cmd_mix0, i_cmd_filt, i_info_sr, i_kind_dev};
                r_len    <= i_data_len;
                r_csum   <= '0;
                r_idx    <= '0;
                r_err    <= !len_ok(i_data_len);
            end else if (w_txen) begin
                r_idx <= r_idx + 12'd1;
                if (r_state == S_BODY) r_csum <= r_csum + w_byte;
            end
        end
    end

    assign o_fd         = (r_state == S_LAST);
    assign o_err        = r_err;
    assign o_fifoc_txen = w_txen;
    assign o_fifoc_txd  = w_byte;
    assign o_so         = r_state;

endmodule
